banked_sram: RTL and testbench

Word-addressed single-port SRAM built from NUM_BANKS equal banks of byte-lane memories. It supports totals that are not a power of two (e.g. 3 × 16 KB = 48 KB), per-byte write enables, an optional registered output stage, and a valid/ready request port. A reset-time sweep, which can also be triggered later, fills every word with INIT_VALUE. The block sits between the core's memory-bus arbiter and the on-chip RAM primitives.

---
 rtl/banked_sram_pkg.sv | 21 ++
 rtl/sram_lane.sv | 21 ++
 rtl/banked_sram.sv | 140 ++++++++++++++
 tb/tb_banked_sram.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/banked_sram_pkg.sv
// banked_sram_pkg: shared state type and elaboration helpers for banked_sram
package banked_sram_pkg;

    typedef enum logic {S_INIT, S_RUN} state_e;

    function automatic int total_depth(input int num_banks, input int bank_addr_width);
        return num_banks << bank_addr_width;
    endfunction

    function automatic bit config_ok(
        input int data_width,
        input int num_banks,
        input int bank_addr_width,
        input int addr_width
    );
        return (data_width % 8 == 0) && (num_banks >= 1) && (num_banks <= 8) &&
               (addr_width < 31) && (addr_width >= bank_addr_width) &&
               ((longint'(1) << addr_width) >= (longint'(num_banks) << bank_addr_width));
    endfunction

endpackage

// File: rtl/sram_lane.sv
// sram_lane: one byte lane of one bank, synchronous-read inferred RAM
module sram_lane #(
    parameter int AW = 12,
    parameter int W  = 8
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  din,
    input  logic          we,
    output logic [W-1:0]  dout
);

    logic [W-1:0] mem [2**AW];

    // read-first single port: a read sees writes from earlier cycles only
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= din;
        dout <= mem[addr];
    end

endmodule

// File: rtl/banked_sram.sv
// banked_sram: word-addressed SRAM built from NUM_BANKS banks of byte lanes with an init sweep
module banked_sram
    import banked_sram_pkg::*;
#(
    parameter int                    DATA_WIDTH      = 32,
    parameter int                    BANK_ADDR_WIDTH = 12,
    parameter int                    NUM_BANKS       = 3,
    parameter int                    ADDR_WIDTH      = 14,
    parameter int                    OUT_REG         = 0,
    parameter int                    INIT_ON_RESET   = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE      = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   din,
    input  logic [DATA_WIDTH/8-1:0] write_en,
    input  logic                    init_req,
    output logic [DATA_WIDTH-1:0]   dout,
    output logic                    dout_valid,
    output logic                    addr_err,
    output logic                    init_done
);

    localparam int LANES = DATA_WIDTH / 8;
    localparam int SEL_W = (ADDR_WIDTH > BANK_ADDR_WIDTH) ? ADDR_WIDTH - BANK_ADDR_WIDTH : 1;
    localparam int DEPTH = total_depth(NUM_BANKS, BANK_ADDR_WIDTH);

    if (!config_ok(DATA_WIDTH, NUM_BANKS, BANK_ADDR_WIDTH, ADDR_WIDTH)) begin : g_bad_cfg
        $error("banked_sram: invalid DATA_WIDTH/NUM_BANKS/BANK_ADDR_WIDTH/ADDR_WIDTH combination");
    end

    state_e                          state_q, state_d;
    logic [BANK_ADDR_WIDTH-1:0]      cnt_q, cnt_d;
    logic                            init_done_q, init_done_d;
    logic                            sweeping, accept, in_range, is_read;
    logic [SEL_W-1:0]                bank_sel, sel1_q, sel1_d;
    logic                            rd1_q, rd1_d, rd_oor1_q, rd_oor1_d, err1_q, err1_d;
    logic                            rd2_q, rd2_d, err2_q, err2_d;
    logic [DATA_WIDTH-1:0]           dq_q, dq_d, mux_data;
    logic [BANK_ADDR_WIDTH-1:0]      lane_addr;
    logic [DATA_WIDTH-1:0]           lane_din;
    logic [NUM_BANKS-1:0][LANES-1:0] lane_we;
    logic [DATA_WIDTH-1:0]           rdata [NUM_BANKS];

    assign sweeping  = state_q == S_INIT;
    assign req_ready = state_q == S_RUN;
    assign accept    = req_valid && req_ready;
    assign is_read   = write_en == '0;
    assign in_range  = {1'b0, addr} < (ADDR_WIDTH + 1)'(DEPTH);
    assign bank_sel  = SEL_W'(addr >> BANK_ADDR_WIDTH);
    assign lane_addr = sweeping ? cnt_q : addr[BANK_ADDR_WIDTH-1:0];
    assign lane_din  = sweeping ? INIT_VALUE : din;

    // sweep counter and INIT/RUN sequencing; init_req is only honoured in RUN
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == S_INIT) begin
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_q == '1) ? S_RUN : S_INIT;
        end else if (init_req) begin
            state_d = S_INIT;
            cnt_d   = '0;
        end
        init_done_d = state_d == S_RUN;
    end

    // sweep writes every lane of every bank; otherwise only enabled lanes of the addressed bank
    always_comb begin
        lane_we = '0;
        for (int b = 0; b < NUM_BANKS; b++)
            lane_we[b] = sweeping ? '1 : (accept && in_range && bank_sel == SEL_W'(b)) ? write_en : '0;
    end

    // output mux driven by the registered bank select; out-of-range reads yield zero
    always_comb begin
        mux_data = '0;
        for (int b = 0; b < NUM_BANKS; b++)
            mux_data = (!rd_oor1_q && sel1_q == SEL_W'(b)) ? rdata[b] : mux_data;
    end

    // read pipeline next state; dq holds the last delivered word between valid pulses
    always_comb begin
        rd1_d     = accept && is_read;
        rd_oor1_d = accept && is_read && !in_range;
        err1_d    = accept && !in_range;
        sel1_d    = accept ? bank_sel : sel1_q;
        rd2_d     = rd1_q;
        err2_d    = err1_q;
        dq_d      = rd1_q ? mux_data : dq_q;
    end

    // all control and pipeline state clears asynchronously; in-flight reads are dropped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= (INIT_ON_RESET != 0) ? S_INIT : S_RUN;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
            sel1_q      <= '0;
            rd1_q       <= 1'b0;
            rd_oor1_q   <= 1'b0;
            err1_q      <= 1'b0;
            rd2_q       <= 1'b0;
            err2_q      <= 1'b0;
            dq_q        <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
            sel1_q      <= sel1_d;
            rd1_q       <= rd1_d;
            rd_oor1_q   <= rd_oor1_d;
            err1_q      <= err1_d;
            rd2_q       <= rd2_d;
            err2_q      <= err2_d;
            dq_q        <= dq_d;
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            sram_lane #(.AW(BANK_ADDR_WIDTH), .W(8)) u_lane (
                .clk  (clk),
                .addr (lane_addr),
                .din  (lane_din[l*8 +: 8]),
                .we   (lane_we[b][l]),
                .dout (rdata[b][l*8 +: 8])
            );
        end
    end

    assign init_done  = init_done_q;
    assign dout       = (OUT_REG != 0) ? dq_q : (rd1_q ? mux_data : dq_q);
    assign dout_valid = (OUT_REG != 0) ? rd2_q : rd1_q;
    assign addr_err   = (OUT_REG != 0) ? err2_q : err1_q;

endmodule

// File: tb/tb_banked_sram.sv
// tb_banked_sram: scoreboard bench driving OUT_REG=0 and OUT_REG=1 instances with shared stimulus
module tb_banked_sram;

    typedef struct {
        logic        v;
        logic        e;
        logic [31:0] d;
        int          c;
    } exp_t;

    logic        clk = 0;
    logic        reset = 1;
    logic        req_valid = 0;
    logic [13:0] addr = '0;
    logic [31:0] din = '0;
    logic [3:0]  write_en = '0;
    logic        init_req = 0;
    logic        ready0, dv0, ae0, done0;
    logic        ready1, dv1, ae1, done1;
    logic [31:0] dout0, dout1;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    exp_t        q0[$];
    exp_t        q1[$];
    exp_t        e0, e1;
    logic        empty0, empty1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    banked_sram #(.DATA_WIDTH(32), .BANK_ADDR_WIDTH(12), .NUM_BANKS(3), .ADDR_WIDTH(14),
                  .OUT_REG(0), .INIT_ON_RESET(1), .INIT_VALUE(32'h0)) u_dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready0), .addr(addr),
        .din(din), .write_en(write_en), .init_req(init_req), .dout(dout0),
        .dout_valid(dv0), .addr_err(ae0), .init_done(done0)
    );

    banked_sram #(.DATA_WIDTH(32), .BANK_ADDR_WIDTH(12), .NUM_BANKS(3), .ADDR_WIDTH(14),
                  .OUT_REG(1), .INIT_ON_RESET(1), .INIT_VALUE(32'h0)) u_dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready1), .addr(addr),
        .din(din), .write_en(write_en), .init_req(init_req), .dout(dout1),
        .dout_valid(dv1), .addr_err(ae1), .init_done(done1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic compare(input string tag, input logic dv, input logic ae, input logic [31:0] dq,
                           input exp_t e, input logic empty);
        if (empty) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_unexpected: valid %b err %b with nothing expected (cycle %0d)", tag, dv, ae, cyc);
        end else begin
            check({tag, "_latency"}, 32'(cyc), 32'(e.c));
            check({tag, "_valid"}, {31'b0, dv}, {31'b0, e.v});
            check({tag, "_addr_err"}, {31'b0, ae}, {31'b0, e.e});
            if (e.v) check({tag, "_data"}, dq, e.d);
        end
    endtask

    // monitor: every output event is matched against the oldest expectation
    always @(negedge clk) begin
        if (!reset) begin
            if (dv0 || ae0) begin
                empty0 = q0.size() == 0;
                if (!empty0) e0 = q0.pop_front();
                compare("o0", dv0, ae0, dout0, e0, empty0);
            end
            if (dv1 || ae1) begin
                empty1 = q1.size() == 0;
                if (!empty1) e1 = q1.pop_front();
                compare("o1", dv1, ae1, dout1, e1, empty1);
            end
        end
    end

    // drive one request for one cycle; reads and out-of-range accesses queue their expected response
    task automatic issue(input logic [13:0] a, input logic [31:0] d, input logic [3:0] we,
                         input logic [31:0] exp, input logic ireq);
        exp_t e;
        logic oor;
        oor = a >= 14'h3000;
        req_valid = 1;
        addr = a;
        din = d;
        write_en = we;
        init_req = ireq;
        check("req_ready", {31'b0, ready0 & ready1}, 32'd1);
        if (we == 4'b0 || oor) begin
            e.v = we == 4'b0;
            e.e = oor;
            e.d = oor ? 32'h0 : exp;
            e.c = cyc + 1;
            q0.push_back(e);
            e.c = cyc + 2;
            q1.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid = 0;
        write_en = '0;
        init_req = 0;
    endtask

    task automatic wr(input logic [13:0] a, input logic [31:0] d, input logic [3:0] we);
        issue(a, d, we, 32'h0, 1'b0);
    endtask

    task automatic rd(input logic [13:0] a, input logic [31:0] exp);
        issue(a, 32'h0, 4'b0, exp, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // count cycles until both instances report init_done, optionally poking init_req mid-sweep
    task automatic wait_run(input bit inject);
        int n;
        bit bad;
        n = 0;
        bad = 0;
        while (!(done0 && done1) && n < 6000) begin
            bad = bad | ready0 | ready1;
            init_req = inject && n == 10;
            @(posedge clk);
            #1;
            n++;
        end
        init_req = 0;
        check("init_cycles", 32'(n), 32'd4096);
        check("ready_low_in_init", {31'b0, bad}, 32'd0);
        check("ready_after_init", {31'b0, ready0 & ready1}, 32'd1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ready"}, {30'b0, ready1, ready0}, 32'd0);
        check({tag, "_init_done"}, {30'b0, done1, done0}, 32'd0);
        check({tag, "_valid_err"}, {28'b0, dv1, ae1, dv0, ae0}, 32'd0);
        check({tag, "_dout0"}, dout0, 32'h0);
        check({tag, "_dout1"}, dout1, 32'h0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        idle(3);
        check_reset_state("reset");
        reset = 0;
        wait_run(1'b0);
        rd(14'h2FFF, 32'h0);
        idle(3);
        wr(14'h1000, 32'hDEADBEEF, 4'b1111);
        wr(14'h1000, 32'h00005500, 4'b0010);
        rd(14'h1000, 32'hDEAD55EF);
        idle(3);
        wr(14'h0FFF, 32'h11, 4'b1111);
        wr(14'h1000, 32'h22, 4'b1111);
        wr(14'h1FFF, 32'h33, 4'b1111);
        wr(14'h2000, 32'h44, 4'b1111);
        rd(14'h0FFF, 32'h11);
        rd(14'h1000, 32'h22);
        rd(14'h1FFF, 32'h33);
        rd(14'h2000, 32'h44);
        idle(4);
        check("hold_dout0", dout0, 32'h44);
        check("hold_dout1", dout1, 32'h44);
        wr(14'h3000, 32'h12345678, 4'b1111);
        rd(14'h0000, 32'h0);
        rd(14'h3FFF, 32'h0);
        idle(3);
        issue(14'h1000, 32'h0, 4'b0, 32'h22, 1'b1);
        wait_run(1'b1);
        rd(14'h0FFF, 32'h0);
        rd(14'h1000, 32'h0);
        rd(14'h1FFF, 32'h0);
        rd(14'h2000, 32'h0);
        idle(3);
        reset = 1;
        idle(2);
        reset = 0;
        idle(100);
        reset = 1;
        #1;
        check_reset_state("mid_sweep_reset");
        idle(2);
        reset = 0;
        wait_run(1'b0);
        rd(14'h2000, 32'h0);
        idle(4);
        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
